// File: rtl/scaler_vout.sv
// Scaler-to-video output stage: pixel FIFO tagged with line/frame ends, drained by a
// sync generator that emits registered de_o / hs_o / vs_o, never two at once.
module scaler_vout #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int HS_W       = 4,
    parameter int VS_W       = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] di_i,
    input  logic                  dv_i,
    input  logic                  eol_i,
    input  logic                  eof_i,
    output logic                  rdy_o,
    output logic [DATA_WIDTH-1:0] do_o,
    output logic                  de_o,
    output logic                  hs_o,
    output logic                  vs_o
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int PMAX = (HS_W > VS_W) ? HS_W : VS_W;
    localparam int PW   = $clog2(PMAX) + 1;
    localparam int EW   = DATA_WIDTH + 2;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] HS_RLD  = PW'(HS_W - 1);
    localparam logic [PW-1:0] VS_RLD  = PW'(VS_W - 1);
    localparam logic [PW-1:0] PONE_C  = PW'(1);

    typedef enum logic [1:0] {INIT_VS, ACTIVE, HS, VS} state_t;

    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  fresh_q;
    logic                  rdy_q;
    state_t                state_q;
    logic [PW-1:0]         pcnt_q;
    logic                  eof_last_q;
    logic [DATA_WIDTH-1:0] do_q;
    logic                  de_q;
    logic                  hs_q;
    logic                  vs_q;
    logic                  push_s;
    logic                  pop_s;
    logic [EW-1:0]         rd_word_s;

    // The word written on the previous edge is not yet readable, giving a two-edge fall-through.
    assign push_s    = dv_i & rdy_q;
    assign pop_s     = (state_q == ACTIVE) && (count_q > {{(CW-1){1'b0}}, fresh_q});
    assign rd_word_s = mem_q[rd_ptr_q];

    // Occupancy next-state from push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; an end of frame also closes the line.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {eof_i, eol_i | eof_i, di_i};
        end
    end

    // FIFO pointers, occupancy and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            fresh_q  <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
            end
            count_q <= count_d;
            fresh_q <= push_s;
            rdy_q   <= (count_d < DEPTH_C);
        end
    end

    // Sync generator FSM with registered video outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT_VS;
            pcnt_q     <= VS_RLD;
            eof_last_q <= 1'b0;
            do_q       <= {DATA_WIDTH{1'b0}};
            de_q       <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
        end else begin
            case (state_q)
                INIT_VS, VS: begin
                    de_q <= 1'b0;
                    hs_q <= 1'b0;
                    vs_q <= 1'b1;
                    if (pcnt_q == {PW{1'b0}}) begin
                        state_q <= ACTIVE;
                    end else begin
                        pcnt_q <= pcnt_q - PONE_C;
                    end
                end
                ACTIVE: begin
                    de_q <= pop_s;
                    hs_q <= 1'b0;
                    vs_q <= 1'b0;
                    if (pop_s) begin
                        do_q       <= rd_word_s[DATA_WIDTH-1:0];
                        eof_last_q <= rd_word_s[EW-1];
                        if (rd_word_s[EW-2]) begin
                            state_q <= HS;
                            pcnt_q  <= HS_RLD;
                        end
                    end
                end
                HS: begin
                    de_q <= 1'b0;
                    hs_q <= 1'b1;
                    vs_q <= 1'b0;
                    if (pcnt_q == {PW{1'b0}}) begin
                        if (eof_last_q) begin
                            state_q <= VS;
                            pcnt_q  <= VS_RLD;
                        end else begin
                            state_q <= ACTIVE;
                        end
                    end else begin
                        pcnt_q <= pcnt_q - PONE_C;
                    end
                end
                default: begin
                    state_q <= INIT_VS;
                    pcnt_q  <= VS_RLD;
                    de_q    <= 1'b0;
                    hs_q    <= 1'b0;
                    vs_q    <= 1'b0;
                end
            endcase
        end
    end

    assign rdy_o = rdy_q;
    assign do_o  = do_q;
    assign de_o  = de_q;
    assign hs_o  = hs_q;
    assign vs_o  = vs_q;

endmodule

// File: doc/scaler_vout.md
SCALER_VOUT -- requirements
Module: scaler_vout

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16: pixel FIFO depth; power of 2, minimum 4.
REQ-003 Parameter HS_W, default 4: hs_o pulse length in clk cycles, minimum 1.
REQ-004 Parameter VS_W, default 4: vs_o pulse length in clk cycles, minimum 1.
REQ-005 clk  input  1  sole clock; all logic is rising-edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 di_i  input  DATA_WIDTH  scaler pixel data.
REQ-008 dv_i  input  1  pixel valid.
REQ-009 eol_i  input  1  qualifies the pixel as the last of its line.
REQ-010 eof_i  input  1  qualifies the pixel as the last of its frame.
REQ-011 rdy_o  output  1  ready; a pixel is accepted on a rising edge with dv_i=1 and rdy_o=1.
REQ-012 do_o  output  DATA_WIDTH  video pixel data, valid when de_o=1.
REQ-013 de_o  output  1  data enable.
REQ-014 hs_o  output  1  line-end pulse.
REQ-015 vs_o  output  1  frame-boundary pulse.

Function
REQ-016 The FIFO stores {eof, eol, data} per accepted pixel; eof_i=1 stores eol=1 regardless of eol_i.
REQ-017 rdy_o=1 when FIFO occupancy < FIFO_DEPTH; rdy_o is derived from registered occupancy only, with no combinational path from dv_i.
REQ-018 The FSM states are INIT_VS, ACTIVE, HS, VS.
REQ-019 INIT_VS: vs_o=1 for VS_W cycles, then go to ACTIVE.
REQ-020 ACTIVE: when the FIFO is non-empty, pop one word per cycle and register do_o=data, de_o=1; when empty, de_o=0 and do_o holds its value.
REQ-021 ACTIVE: popping a word with eol=1 goes to HS on the same edge.
REQ-022 HS: de_o=0, hs_o=1 for HS_W cycles; then go to VS if the last popped word had eof=1, else go to ACTIVE.
REQ-023 VS: vs_o=1 for VS_W cycles, then go to ACTIVE.
REQ-024 de_o, hs_o and vs_o are all registered; no two of them are ever 1 in the same cycle.
REQ-025 The FIFO never pops in INIT_VS, HS or VS; input acceptance continues in all states while rdy_o=1.
REQ-026 Latency: a pixel accepted at edge k into an empty FIFO, while in ACTIVE, appears on do_o/de_o after edge k+2.
REQ-027 Simultaneous push and pop in one cycle leaves occupancy unchanged.
REQ-028 No push is possible when full, because rdy_o=0.
REQ-029 No pop is possible when empty.
REQ-030 Pointers wrap modulo FIFO_DEPTH; occupancy counter width is $clog2(FIFO_DEPTH)+1.
REQ-031 Pulse counters are $clog2(max(HS_W,VS_W))+1 bits wide and reload on each state entry.
REQ-032 Pixels with dv_i=0 are ignored, along with their eol_i and eof_i.
REQ-033 No line or frame length is checked; line length equals the number of pixels popped between hs_o pulses.

Reset
REQ-034 rst_n=0 immediately forces do_o=0, de_o=0, hs_o=0, vs_o=0, rdy_o=0, clears FIFO pointers and occupancy, and sets the state to INIT_VS.
REQ-035 On the first rising edge with rst_n=1: rdy_o=1, and the INIT_VS pulse starts.
REQ-036 Reset asserted mid-line or mid-pulse discards all FIFO contents; no stale pixel is output after release.

Verification
REQ-037 Reset release, no input -> vs_o=1 for exactly 4 cycles starting after the first edge; afterwards all outputs stay 0 and rdy_o=1.
REQ-038 A 4x2 frame, data 1..8, dv_i continuous, eol on 4 and 8, eof on 8 -> de_o bursts 1,2,3,4 then hs_o x4, then 5,6,7,8, hs_o x4, vs_o x4.
REQ-039 FIFO_DEPTH=4, HS_W=8: 1-pixel line with eol, then 10 continuous pixels -> rdy_o drops to 0 while the FIFO is full during HS; all 10 pixels are output in order with none lost or duplicated.
REQ-040 dv_i asserted every third cycle, 3-pixel line -> de_o shows gaps; hs_o rises only after the eol pixel is output.
REQ-041 rst_n pulled low after the 2nd pixel of a 4-pixel line -> outputs are 0 in the same cycle; after release there is one vs_o pulse of 4 cycles and no old data appears on de_o.
REQ-042 A pixel with eof_i=1 and eol_i=0 -> handled as end of line: hs_o x4, then vs_o x4.
